// File: rtl/dual_port_sram_arbiter.sv
// Arbiter sharing one single-ported synchronous SRAM between instruction fetch
// and the data port. Data has priority; a starvation counter bounds fetch waits.

module dual_port_sram_arbiter_chk #(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              reset,
  input logic              if_req,
  input logic              if_gnt,
  input logic [ADDR_W-1:0] if_addr,
  input logic              mem_req,
  input logic              mem_gnt,
  input logic              if_rvalid,
  input logic              mem_rvalid
);

  a_if_req_held: assert property (@(posedge clk) disable iff (reset)
    (if_req && !if_gnt) |=> if_req);

  a_mem_req_held: assert property (@(posedge clk) disable iff (reset)
    (mem_req && !mem_gnt) |=> mem_req);

  a_if_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (if_req && !if_gnt) |=> $stable(if_addr));

  a_one_grant: assert property (@(posedge clk) !(if_gnt && mem_gnt));

  a_one_rvalid: assert property (@(posedge clk) !(if_rvalid && mem_rvalid));

  a_if_gnt_has_req: assert property (@(posedge clk) if_gnt |-> if_req);

  a_mem_gnt_has_req: assert property (@(posedge clk) mem_gnt |-> mem_req);

endmodule

module dual_port_sram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_wen,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_INST = 2'd1,
    TAG_DATA = 2'd2
  } tag_e;

  localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);
  localparam logic [3:0] STARVE_MAX_C   = 4'd15;

  tag_e       tag_r;
  tag_e       tag_nxt_s;
  logic [3:0] starve_cnt_r;
  logic [3:0] starve_cnt_nxt_s;
  logic       fetch_wins_s;
  logic       if_gnt_s;
  logic       mem_gnt_s;

  // Arbitration; reset suppresses every grant combinationally
  always_comb begin
    fetch_wins_s = 1'b0;
    if_gnt_s     = 1'b0;
    mem_gnt_s    = 1'b0;
    if (reset) begin
      fetch_wins_s = 1'b0;
    end else begin
      fetch_wins_s = if_req && (!mem_req || (starve_cnt_r >= STARVE_LIMIT_C));
      if_gnt_s     = fetch_wins_s;
      mem_gnt_s    = mem_req && !fetch_wins_s;
    end
  end

  assign if_gnt  = if_gnt_s;
  assign mem_gnt = mem_gnt_s;

  // SRAM command mux; fetch never writes, so its write fields stay zero
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = {ADDR_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    if (if_gnt_s) begin
      sram_en   = 1'b1;
      sram_addr = if_addr;
    end else if (mem_gnt_s) begin
      sram_en    = 1'b1;
      sram_wen   = mem_wen;
      sram_addr  = mem_addr;
      sram_wdata = mem_wdata;
    end else begin
      sram_en = 1'b0;
    end
  end

  // Response tag next state: records who owns next cycle's read data
  always_comb begin
    tag_nxt_s = TAG_NONE;
    if (if_gnt_s) begin
      tag_nxt_s = TAG_INST;
    end else if (mem_gnt_s && (mem_wen == 4'b0000)) begin
      tag_nxt_s = TAG_DATA;
    end else begin
      tag_nxt_s = TAG_NONE;
    end
  end

  // Starvation counter next value, saturating
  always_comb begin
    starve_cnt_nxt_s = 4'd0;
    if (if_req && !if_gnt_s) begin
      if (starve_cnt_r != STARVE_MAX_C) begin
        starve_cnt_nxt_s = starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_nxt_s = starve_cnt_r;
      end
    end else begin
      starve_cnt_nxt_s = 4'd0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_r        <= TAG_NONE;
      starve_cnt_r <= 4'd0;
    end else begin
      tag_r        <= tag_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Response steering; a read in flight when reset rises is dropped
  always_comb begin
    if_rvalid  = 1'b0;
    mem_rvalid = 1'b0;
    case (tag_r)
      TAG_INST: if_rvalid  = !reset;
      TAG_DATA: mem_rvalid = !reset;
      default:  begin
        if_rvalid  = 1'b0;
        mem_rvalid = 1'b0;
      end
    endcase
  end

  assign if_rdata  = sram_rdata;
  assign mem_rdata = sram_rdata;

  dual_port_sram_arbiter_chk #(
    .ADDR_W (ADDR_W)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_gnt     (if_gnt_s),
    .if_addr    (if_addr),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt_s),
    .if_rvalid  (if_rvalid),
    .mem_rvalid (mem_rvalid)
  );

endmodule

// File: tb/tb_dual_port_sram_arbiter.sv
// Directed, table-driven bench for dual_port_sram_arbiter with a behavioural
// byte-writable SRAM model behind the SRAM port.
module tb_dual_port_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dual_port_sram_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // SRAM model: zeroed at start except word 0x100 which holds 0xDEADBEEF
  logic [31:0] mem_arr [0:255];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
      mem_arr[64] <= 32'hDEADBEEF;
      init_done   <= 1'b1;
    end else if (sram_en) begin
      if (sram_wen != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) mem_arr[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem_arr[sram_addr[9:2]];
      end
    end
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        e_if_gnt;
    logic        e_mem_gnt;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_rv;
    logic        e_mem_rv;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic mr, logic [31:0] ma,
                              logic [3:0] mw, logic [31:0] md, logic eig, logic emg,
                              logic [3:0] ew, logic [31:0] ea, logic [31:0] ed,
                              logic eir, logic emr, logic [31:0] erd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.mem_req = mr; v.mem_addr = ma;
    v.mem_wen = mw; v.mem_wdata = md; v.e_if_gnt = eig; v.e_mem_gnt = emg;
    v.e_wen = ew; v.e_addr = ea; v.e_wdata = ed;
    v.e_if_rv = eir; v.e_mem_rv = emr; v.e_rdata = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic mr,
                       input logic [31:0] ma, input logic [3:0] mw, input logic [31:0] md);
    if_req = ir; if_addr = ia; mem_req = mr; mem_addr = ma; mem_wen = mw; mem_wdata = md;
  endtask

  vec_t vecs [$];

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 32'h20, 4'h0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_gnt", {if_gnt, mem_gnt}, 2'b00);
    check("reset_sram", {sram_en, sram_wen, sram_addr, sram_wdata}, 69'h0);
    check("reset_rvalid", {if_rvalid, mem_rvalid}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;

    // Expected rvalid/rdata in each record answer the previous record's grant
    vecs.push_back(mk(0, 32'h1FC, 0, 32'h3C, 4'hF, 32'h11111111, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,  4'h0, 32'h0,        1, 0, 4'h0, 32'h100, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h20, 4'h3, 32'h1234ABCD, 0, 1, 4'h3, 32'h20,  32'h1234ABCD, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 32'h0,   1, 32'h20, 4'h0, 32'h0,        0, 1, 4'h0, 32'h20,  32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h100, 1, 32'h20, 4'h0, 32'hCAFEF00D, 0, 1, 4'h0, 32'h20,  32'hCAFEF00D, 0, 1, 32'h0000ABCD));
    vecs.push_back(mk(1, 32'h100, 1, 32'h20, 4'h0, 32'hCAFEF00D, 0, 1, 4'h0, 32'h20,  32'hCAFEF00D, 0, 1, 32'h0000ABCD));
    vecs.push_back(mk(1, 32'h100, 1, 32'h20, 4'h0, 32'hCAFEF00D, 0, 1, 4'h0, 32'h20,  32'hCAFEF00D, 0, 1, 32'h0000ABCD));
    vecs.push_back(mk(1, 32'h100, 1, 32'h20, 4'h0, 32'hCAFEF00D, 1, 0, 4'h0, 32'h100, 32'h0,        0, 1, 32'h0000ABCD));
    vecs.push_back(mk(1, 32'h100, 1, 32'h20, 4'h0, 32'hCAFEF00D, 0, 1, 4'h0, 32'h20,  32'hCAFEF00D, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,  4'h0, 32'h0,        1, 0, 4'h0, 32'h100, 32'h0,        0, 1, 32'h0000ABCD));
    vecs.push_back(mk(0, 32'h0,   1, 32'h20, 4'h0, 32'h0,        0, 1, 4'h0, 32'h20,  32'h0,        1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,  4'h0, 32'h0,        1, 0, 4'h0, 32'h100, 32'h0,        0, 1, 32'h0000ABCD));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,  4'h0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 32'h100, 1, 32'h24, 4'hF, 32'h55AA55AA, 0, 1, 4'hF, 32'h24,  32'h55AA55AA, 0, 0, 32'h0));
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,  4'h0, 32'h0,        1, 0, 4'h0, 32'h100, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,   1, 32'h24, 4'h0, 32'h0,        0, 1, 4'h0, 32'h24,  32'h0,        1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,  4'h0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h55AA55AA));

    foreach (vecs[i]) begin
      drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].mem_req, vecs[i].mem_addr,
            vecs[i].mem_wen, vecs[i].mem_wdata);
      @(negedge clk);
      check($sformatf("v%0d_gnt", i), {if_gnt, mem_gnt}, {vecs[i].e_if_gnt, vecs[i].e_mem_gnt});
      check($sformatf("v%0d_sram", i), {sram_en, sram_wen, sram_addr, sram_wdata},
            {vecs[i].e_if_gnt | vecs[i].e_mem_gnt, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_wdata});
      check($sformatf("v%0d_rvalid", i), {if_rvalid, mem_rvalid}, {vecs[i].e_if_rv, vecs[i].e_mem_rv});
      if (vecs[i].e_if_rv) check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_mem_rv) check($sformatf("v%0d_mem_rdata", i), mem_rdata, vecs[i].e_rdata);
      @(posedge clk); #1;
    end

    // Reset lands right after a data-read grant with fetch three cycles starved
    drive(1'b1, 32'h100, 1'b1, 32'h20, 4'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("pre_rst%0d_gnt", k), {if_gnt, mem_gnt}, 2'b01);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("in_rst_gnt", {if_gnt, mem_gnt, sram_en}, 3'b000);
    check("in_rst_rvalid", {if_rvalid, mem_rvalid}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", {if_rvalid, mem_rvalid}, 2'b00);
    check("post_rst_gnt", {if_gnt, mem_gnt}, 2'b01);
    @(posedge clk); #1;
    drive(1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("post_rst_mem_rvalid", {if_rvalid, mem_rvalid}, 2'b01);
    check("post_rst_if_gnt", {if_gnt, mem_gnt}, 2'b10);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check("post_rst_if_rvalid", {if_rvalid, mem_rvalid}, 2'b10);
    check("post_rst_if_rdata", if_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_port_sram_arbiter.md
Name: dual_port_sram_arbiter

Overview:
Shares one single-ported synchronous SRAM between the instruction-fetch requester and the memory-stage data requester of the 5-stage CPU. Each cycle it grants at most one request and drives the SRAM enable, write-enable, address and write data. It steers the one-cycle-latency read data back to the requester that owns it. Data accesses have priority, and a starvation counter forces an instruction grant after a bounded number of consecutive instruction denials.

Parameters:
ADDR_W, 32, width of the address buses
DATA_W, 32, width of the data buses
STARVE_LIMIT, 3, consecutive denied instruction-request cycles after which fetch wins arbitration (range 1..15)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous reset, active-high
if_req  input  1  fetch read request; held until if_gnt
if_addr  input  ADDR_W  fetch address; stable while if_req is high
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  if_rdata valid this cycle
if_rdata  output  DATA_W  fetch read data
mem_req  input  1  data request; held until mem_gnt
mem_addr  input  ADDR_W  data address
mem_wen  input  4  byte write enables; 0 means read
mem_wdata  input  DATA_W  write data
mem_gnt  output  1  data request accepted this cycle
mem_rvalid  output  1  mem_rdata valid this cycle; reads only
mem_rdata  output  DATA_W  data read data
sram_en  output  1  SRAM enable
sram_wen  output  4  SRAM byte write enables
sram_addr  output  ADDR_W  SRAM address
sram_wdata  output  DATA_W  SRAM write data
sram_rdata  input  DATA_W  SRAM read data; valid the cycle after an enabled read

Behaviour:
- Reset (synchronous, active-high, sampled on the clk edge):
  - starve_cnt clears to 0.
  - Response tag clears to NONE.
  - if_rvalid and mem_rvalid are 0 in the cycle after reset is sampled.
  - A read in flight when reset is asserted is discarded; no rvalid is produced for it.
  - Combinational grant outputs are forced to 0 while reset is high.
- Arbitration is combinational within the cycle:
  - fetch_wins = if_req and (not mem_req or starve_cnt >= STARVE_LIMIT).
  - if_gnt = fetch_wins.
  - mem_gnt = mem_req and not fetch_wins.
  - At most one grant per cycle. Grants are zero-latency: a request may be granted in the same cycle it is raised.
- SRAM drive:
  - sram_en = if_gnt or mem_gnt.
  - On a fetch grant: sram_addr = if_addr, sram_wen = 0, sram_wdata = 0.
  - On a data grant: sram_addr = mem_addr, sram_wen = mem_wen, sram_wdata = mem_wdata.
  - With no grant, all SRAM outputs are 0.
- Response tag register, 2-bit, values NONE/INST/DATA. Next value:
  - INST if if_gnt.
  - DATA if mem_gnt and mem_wen == 0.
  - NONE otherwise, including data writes.
- Read returns:
  - if_rvalid = (tag == INST); mem_rvalid = (tag == DATA).
  - Both rdata outputs pass sram_rdata through unmodified; they are don't-care when the matching rvalid is low.
  - Read latency is exactly 1 cycle from grant. Back-to-back grants give back-to-back rvalids with no bubbles.
- starve_cnt, 4-bit:
  - Increments when if_req and not if_gnt, saturating at 15.
  - Clears to 0 on if_gnt or when if_req is low.
- Simultaneous requests below the limit: data wins and fetch waits.
- Once the limit is reached: fetch wins once, the counter clears, and data wins again the next cycle.
- A write followed by a read of the same address on the next cycle returns the new data; the SRAM provides this ordering and no forwarding is added.
- Requesters must not drop req before gnt. Behaviour when they do is undefined; the checker flags it.

Test Plan:
- Reset then idle -> all grants, rvalids and sram_en are 0; starve_cnt = 0.
- Fetch-only read of addr 0x100, SRAM returns 0xDEADBEEF -> if_gnt in cycle 0, sram_en = 1, sram_wen = 0; cycle 1: if_rvalid = 1, if_rdata = 0xDEADBEEF, mem_rvalid = 0.
- Data write mem_wen = 4'b0011 to 0x20 with wdata 0x1234ABCD, then data read of 0x20 -> sram_wen = 0011 on the write; no rvalid for the write; the read returns 0x0000ABCD assuming the SRAM was pre-zeroed.
- Both requests held continuously with STARVE_LIMIT = 3 -> grant pattern D,D,D,I,D,D,D,I…; rvalid tags follow one cycle later.
- Alternating fetch and data reads every cycle -> each rvalid is asserted exactly one cycle after its grant, with no bubbles and no cross-steering.
- Reset asserted the cycle after a data-read grant -> no mem_rvalid is produced; starve_cnt = 0; the first grant after reset follows the normal priority rules.
